addsub_seq16: RTL and testbench

ADDSUB_SEQ16 -- requirements
Module: addsub_seq16

---
 rtl/addsub_seq16_pkg.sv | 13 +
 rtl/addsub_seq16_nibble_add4.sv | 17 +
 rtl/addsub_seq16.sv | 152 +++++++++++++++
 tb/tb_addsub_seq16.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq16_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
package addsub_seq16_pkg;

  // Width of the arithmetic slice processed each cycle.
  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/addsub_seq16_nibble_add4.sv
// nibble_add4: combinational 4-bit adder slice with explicit carry-in and carry-out.
module nibble_add4
  import addsub_seq16_pkg::*;
(
  input  logic [NibbleW-1:0] a_i,
  input  logic [NibbleW-1:0] b_i,
  input  logic               cin_i,
  output logic [NibbleW-1:0] sum_o,
  output logic               cout_o
);

  // Plain ripple sum of both nibbles plus the incoming carry.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{NibbleW{1'b0}}, cin_i};
  end

endmodule

// File: rtl/addsub_seq16.sv
// addsub_seq16: nibble-serial adder/subtractor, one nibble per clock, LSB first.
// Optional feature macro ADDSUB_SEQ_CHAIN_EN adds a CHAIN input that seeds the
// running carry with the raw carry of the previous operation (multi-word arithmetic).
module addsub_seq16
  import addsub_seq16_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic                       SUB,
  input  logic [NibbleW*NIBBLES-1:0] A,
  input  logic [NibbleW*NIBBLES-1:0] B,
`ifdef ADDSUB_SEQ_CHAIN_EN
  input  logic                       CHAIN,
`endif
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NibbleW*NIBBLES-1:0] ANS,
  output logic                       CY_BR_OUT,
  output logic                       OVF
);

  localparam int unsigned W       = NibbleW * NIBBLES;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              sub_q, sub_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      ans_q, ans_d;
  logic              cy_q, cy_d;
  logic              ovf_q, ovf_d;
`ifdef ADDSUB_SEQ_CHAIN_EN
  logic              raw_cy_q, raw_cy_d;
`endif

  logic [NibbleW-1:0] nib_a, nib_b, nib_sum;
  logic               nib_cout;

  // Select the current nibble; subtraction feeds the inverted B nibble.
  always_comb begin
    nib_a = a_q[idx_q*NibbleW +: NibbleW];
    nib_b = b_q[idx_q*NibbleW +: NibbleW] ^ {NibbleW{sub_q}};
  end

  nibble_add4 u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  // Next-state logic: latch operands on START, step one nibble per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    ans_d   = ans_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
`ifdef ADDSUB_SEQ_CHAIN_EN
    raw_cy_d = raw_cy_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StRun;
          a_d     = A;
          b_d     = B;
          sub_d   = SUB;
          idx_d   = '0;
`ifdef ADDSUB_SEQ_CHAIN_EN
          carry_d = CHAIN ? raw_cy_q : SUB;
`else
          carry_d = SUB;
`endif
        end
      end
      StRun: begin
        ans_d[idx_q*NibbleW +: NibbleW] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StFin;
          // Carry out for add, borrow (inverted carry) for subtract.
          cy_d    = nib_cout ^ sub_q;
          // Like-signed operands (after B inversion) producing a different sign.
          ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (nib_sum[NibbleW-1] != a_q[W-1]);
`ifdef ADDSUB_SEQ_CHAIN_EN
          raw_cy_d = nib_cout;
`endif
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ans_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDSUB_SEQ_CHAIN_EN
      raw_cy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      ans_q   <= ans_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
`ifdef ADDSUB_SEQ_CHAIN_EN
      raw_cy_q <= raw_cy_d;
`endif
    end
  end

  // Output decode.
  always_comb begin
    BUSY      = (state_q != StIdle);
    DONE      = (state_q == StFin);
    ANS       = ans_q;
    CY_BR_OUT = cy_q;
    OVF       = ovf_q;
  end

endmodule

// File: tb/tb_addsub_seq16.sv
// Scoreboard bench for addsub_seq16: driver pushes model results, monitor pops on DONE.
module tb_addsub_seq16;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 16;

  typedef struct {
    logic [W-1:0] ans;
    logic         cy;
    logic         ovf;
    logic         raw;
    int           done_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] ans;
  logic         cy_br;
  logic         ovf;
`ifdef ADDSUB_SEQ_CHAIN_EN
  logic         chain;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  exp_t last;
  exp_t mon_e;
  logic prev_raw;

  addsub_seq16 #(
    .NIBBLES (NIBBLES)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .SUB       (sub),
    .A         (a),
    .B         (b),
`ifdef ADDSUB_SEQ_CHAIN_EN
    .CHAIN     (chain),
`endif
    .BUSY      (busy),
    .DONE      (done),
    .ANS       (ans),
    .CY_BR_OUT (cy_br),
    .OVF       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-word integer arithmetic with an explicit carry/borrow in.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic isub, input logic cin);
    exp_t   r;
    longint t;
    longint sa;
    longint sb;
    longint s;
    r.done_cyc = 0;
    if (!isub) begin
      t     = longint'(ia) + longint'(ib) + longint'(cin);
      r.raw = (t >= 65536);
    end else begin
      t     = longint'(ia) - longint'(ib) - (1 - longint'(cin));
      r.raw = (t >= 0);
    end
    r.ans = t[W-1:0];
    r.cy  = isub ? !r.raw : r.raw;
    sa    = ia[W-1] ? longint'(ia) - 65536 : longint'(ia);
    sb    = ib[W-1] ? longint'(ib) - 65536 : longint'(ib);
    s     = isub ? sa - sb - (1 - longint'(cin)) : sa + sb + longint'(cin);
    r.ovf = (s > 32767) || (s < -32768);
    return r;
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: DONE at cycle %0d with no operation outstanding", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ans", 64'(ans), 64'(mon_e.ans));
        chk("cy_br_out", 64'(cy_br), 64'(mon_e.cy));
        chk("ovf", 64'(ovf), 64'(mon_e.ovf));
        chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
      end
    end
  end

  // Issue one operation from a falling edge; optionally spray ignored STARTs while busy.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic ichain, input bit junk);
    exp_t r;
    logic cin;
    int   guard;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: BUSY still high after %0d cycles", guard);
    end
    chk("hold_ans", 64'(ans), 64'(last.ans));
    chk("hold_cy_br_out", 64'(cy_br), 64'(last.cy));
    chk("hold_ovf", 64'(ovf), 64'(last.ovf));
    cin = isub;
`ifdef ADDSUB_SEQ_CHAIN_EN
    chain = ichain;
    if (ichain) cin = prev_raw;
`else
    if (ichain) $display("note: chaining requested but not built in");
`endif
    r          = model(ia, ib, isub, cin);
    r.done_cyc = cyc + 1 + NIBBLES;
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    sb_q.push_back(r);
    last     = r;
    prev_raw = r.raw;
    @(negedge clk);
    start = 1'b0;
    if (junk) begin
      for (int j = 0; j < NIBBLES + 1; j++) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SEQ_CHAIN_EN
        chain = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
      end
      start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0 || busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, busy=%0b", sb_q.size(), busy);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h7FFF;
      3:       v = 16'h8000;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
`ifdef ADDSUB_SEQ_CHAIN_EN
    chain    = 1'b0;
`endif
    last     = '{default: 0};
    prev_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ans", 64'(ans), 64'd0);
    chk("rst_cy_br_out", 64'(cy_br), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed corner vectors.
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // START on RUN cycles 2 and 4 must be ignored.
    do_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset asserted during RUN cycle 2 discards the operation.
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_ans", 64'(ans), 64'd0);
    chk("midrst_cy_br_out", 64'(cy_br), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    sb_q.delete();
    last     = '{default: 0};
    prev_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    wait_drain();

`ifdef ADDSUB_SEQ_CHAIN_EN
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    wait_drain();
`endif

    // Randomized traffic with gaps, back-to-back starts and ignored STARTs.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      logic         rc;
      bit           rj;
      ra = pick_operand();
      rb = pick_operand();
      rs = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SEQ_CHAIN_EN
      rc = 1'($urandom_range(0, 1));
`else
      rc = 1'b0;
`endif
      rj = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(ra, rb, rs, rc, rj);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
